fetch_line_sender: RTL



---
 rtl/fetch_line_sender.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fetch_line_sender.sv
// Fetch-side line producer: issues line-aligned I-cache requests under a credit limit and
// buffers in-order responses in a skid FIFO for the instruction buffer.
// Optional perf counters are enabled with `define FETCH_LINE_SENDER_PERF_EN.
`timescale 1ns/1ps
module fetch_line_sender #(
    parameter int                 ICACHE_DATA_W = 128,
    parameter int                 VADDR_W       = 39,
    parameter int                 DEPTH         = 2,
    parameter logic [VADDR_W-1:0] RESET_VADDR   = 'h8000_0000
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_flush_valid,
    input  logic [VADDR_W-1:0]         i_flush_vaddr,
    output logic                       o_ic_req_valid,
    input  logic                       i_ic_req_ready,
    output logic [VADDR_W-1:0]         o_ic_req_vaddr,
    input  logic                       i_ic_resp_valid,
    input  logic [ICACHE_DATA_W-1:0]   i_ic_resp_data,
    output logic                       o_inst_vld,
    input  logic                       i_inst_rdy,
    output logic [ICACHE_DATA_W-1:0]   o_inst_out,
    output logic [ICACHE_DATA_W/8-1:0] o_inst_byte_en
`ifdef FETCH_LINE_SENDER_PERF_EN
    ,
    output logic [31:0]                o_perf_stall_cnt,
    output logic [31:0]                o_perf_kill_cnt
`endif
);
    localparam int B     = ICACHE_DATA_W / 8;
    localparam int OFS_W = $clog2(B);
    localparam int CNT_W = $clog2(DEPTH + 1) + 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [VADDR_W-1:0] LINE_MASK = ~(VADDR_W'(B) - VADDR_W'(1));

    logic [VADDR_W-1:0] req_vaddr_q, req_vaddr_d;
    logic [OFS_W-1:0]   start_ofs_q, start_ofs_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   kill_cnt_q, kill_cnt_d;
    logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic               first_line_q, first_line_d;

    logic [ICACHE_DATA_W-1:0] data_mem [DEPTH];
    logic                     tag_mem  [DEPTH];

    logic req_fire, push, pop;
    logic [B-1:0] head_mask;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit covers both in-flight requests and buffered lines, so the FIFO cannot overflow.
    assign o_ic_req_valid = i_reset_n && !i_flush_valid && (kill_cnt_q == '0) &&
                            ((outstanding_q + fifo_cnt_q) < CNT_W'(DEPTH));
    assign o_ic_req_vaddr = req_vaddr_q;
    assign req_fire       = o_ic_req_valid && i_ic_req_ready;
    assign push           = i_ic_resp_valid && (kill_cnt_q == '0) && !i_flush_valid;
    assign o_inst_vld     = (fifo_cnt_q != '0);
    assign pop            = o_inst_vld && i_inst_rdy;

    always_comb begin
        req_vaddr_d   = req_vaddr_q;
        start_ofs_d   = start_ofs_q;
        kill_cnt_d    = kill_cnt_q;
        fifo_cnt_d    = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
        rd_ptr_d      = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d      = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        first_line_d  = push ? 1'b0 : first_line_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(i_ic_resp_valid);
        if (req_fire)
            req_vaddr_d = req_vaddr_q + VADDR_W'(B);
        if (i_ic_resp_valid && (kill_cnt_q != '0))
            kill_cnt_d = kill_cnt_q - CNT_W'(1);
        if (i_flush_valid) begin
            // Everything still in flight after this edge belongs to the old stream.
            kill_cnt_d   = outstanding_d;
            fifo_cnt_d   = '0;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            req_vaddr_d  = i_flush_vaddr & LINE_MASK;
            start_ofs_d  = i_flush_vaddr[OFS_W-1:0];
            first_line_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            req_vaddr_q   <= RESET_VADDR & LINE_MASK;
            start_ofs_q   <= RESET_VADDR[OFS_W-1:0];
            outstanding_q <= '0;
            kill_cnt_q    <= '0;
            fifo_cnt_q    <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            first_line_q  <= 1'b1;
        end else begin
            req_vaddr_q   <= req_vaddr_d;
            start_ofs_q   <= start_ofs_d;
            outstanding_q <= outstanding_d;
            kill_cnt_q    <= kill_cnt_d;
            fifo_cnt_q    <= fifo_cnt_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            first_line_q  <= first_line_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= i_ic_resp_data;
            tag_mem[wr_ptr_q]  <= first_line_q;
        end
    end

    // start_ofs only changes on flush, which also empties the FIFO, so it is safe to apply at the head.
    always_comb begin
        head_mask = '1;
        if (tag_mem[rd_ptr_q])
            head_mask = {B{1'b1}} << start_ofs_q;
    end

    assign o_inst_out     = data_mem[rd_ptr_q];
    assign o_inst_byte_en = o_inst_vld ? head_mask : '0;

`ifdef FETCH_LINE_SENDER_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_kill_q, perf_kill_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_kill_d  = perf_kill_q;
        if (o_inst_vld && !i_inst_rdy && (perf_stall_q != '1))
            perf_stall_d = perf_stall_q + 32'd1;
        if (i_ic_resp_valid && ((kill_cnt_q != '0) || i_flush_valid) && (perf_kill_q != '1))
            perf_kill_d = perf_kill_q + 32'd1;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            perf_stall_q <= '0;
            perf_kill_q  <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_kill_q  <= perf_kill_d;
        end
    end

    assign o_perf_stall_cnt = perf_stall_q;
    assign o_perf_kill_cnt  = perf_kill_q;
`endif
endmodule
